ecc_scrub_mem: RTL and testbench

ECC_SCRUB_MEM -- requirements
Module: ecc_scrub_mem

---
 rtl/ecc_pkg.sv | 73 +++++++
 rtl/ecc_secded_dec.sv | 53 +++++
 rtl/ecc_scrub_mem.sv | 148 ++++++++++++++
 tb/tb_ecc_scrub_mem.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED definitions for the scrubbed memory.
//   calc_r    - number of Hamming check bits for a given data width
//   pos_of    - Hamming position of a data bit (MSB data bit sits at position 3)
//   encode    - builds {parity, check bits, data}, sized for up to MAX_DATA_W data bits
//   dec_res_t - decoder result {data, ce, ue}
package ecc_pkg;

    localparam int unsigned MAX_DATA_W = 57;
    localparam int unsigned MAX_CW     = 64;
    localparam int unsigned SYN_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCRUB_RD,
        SCRUB_WB
    } scrub_state_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  ce;
        logic                  ue;
    } dec_res_t;

    // Smallest r with 2^r >= dw + r + 1.
    function automatic int unsigned calc_r(input int unsigned dw);
        int unsigned r;
        r = 1;
        for (int unsigned k = 0; k < 8; k++) begin
            if ((32'd1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    // Data bits map, highest index first, onto ascending non-power-of-two positions.
    function automatic int unsigned pos_of(input int unsigned dw, input int unsigned idx);
        int unsigned rank;
        int unsigned seen;
        int unsigned pos;
        rank = dw - 1 - idx;
        seen = 0;
        pos  = 0;
        for (int unsigned p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == rank) pos = p;
                seen = seen + 1;
            end
        end
        return pos;
    endfunction

    // Check vector is the XOR of the positions of all set data bits.
    function automatic logic [MAX_CW-1:0] encode(input int unsigned dw,
                                                 input logic [MAX_DATA_W-1:0] data);
        logic [MAX_CW-1:0] cw;
        logic [SYN_W-1:0]  chk;
        int unsigned       r;
        r   = calc_r(dw);
        cw  = '0;
        chk = '0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i < dw) begin
                cw[i] = data[i];
                if (data[i]) chk = chk ^ SYN_W'(pos_of(dw, i));
            end
        end
        for (int unsigned k = 0; k < SYN_W; k++) begin
            if (k < r) cw[dw + k] = chk[k];
        end
        cw[dw + r] = ^cw;
        return cw;
    endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// ecc_secded_dec: combinational SECDED decoder.
//   codeword - stored word {parity, check bits, data}
//   result   - corrected (or raw, when uncorrectable) data plus ce/ue flags
module ecc_secded_dec
    import ecc_pkg::*;
#(
    parameter  int unsigned DATA_W = 11,
    localparam int unsigned R      = calc_r(DATA_W),
    localparam int unsigned CW     = DATA_W + R + 1
) (
    input  logic [CW-1:0] codeword,
    output dec_res_t      result
);

    logic [SYN_W-1:0]  syn;
    logic              par;
    logic [DATA_W-1:0] corr;
    logic              ce;
    logic              ue;

    // Syndrome is the XOR of the positions of every set bit in the Hamming part.
    always_comb begin
        syn  = '0;
        par  = ^codeword;
        corr = codeword[DATA_W-1:0];
        ce   = 1'b0;
        ue   = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (codeword[i]) syn = syn ^ SYN_W'(pos_of(DATA_W, i));
        end
        for (int unsigned k = 0; k < R; k++) begin
            if (codeword[DATA_W + k]) syn = syn ^ SYN_W'(32'd1 << k);
        end
        if (par) begin
            // syn==0 means the overall parity bit itself flipped
            if (syn <= SYN_W'(DATA_W + R)) begin
                ce = 1'b1;
                for (int unsigned i = 0; i < DATA_W; i++) begin
                    if (syn == SYN_W'(pos_of(DATA_W, i))) corr[i] = ~corr[i];
                end
            end else begin
                ue = 1'b1;
            end
        end else if (syn != '0) begin
            ue = 1'b1;
        end
        result      = '0;
        result.data = MAX_DATA_W'(corr);
        result.ce   = ce;
        result.ue   = ue;
    end

endmodule

// File: rtl/ecc_scrub_mem.sv
// ecc_scrub_mem: SECDED-protected register-file memory with background scrubber.
//   clock, reset_n       - clock, async active-low reset
//   req_*                - host request (valid/ready, we, addr, wdata)
//   inj_mask             - XOR error mask applied to host-write codewords
//   rsp_*                - one-cycle read response with ce/ue flags
//   scrub_en             - enables the periodic scrubber
//   cnt_clr              - clears the error counters
//   ce_count, ue_count   - saturating error counters; err_addr = latest error address
module ecc_scrub_mem
    import ecc_pkg::*;
#(
    parameter  int unsigned DATA_W         = 11,
    parameter  int unsigned DEPTH          = 16,
    parameter  int unsigned SCRUB_INTERVAL = 64,
    parameter  int unsigned CNT_W          = 8,
    localparam int unsigned CW             = DATA_W + calc_r(DATA_W) + 1,
    localparam int unsigned ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_ce,
    output logic              rsp_ue,
    input  logic [CW-1:0]     inj_mask,
    input  logic              scrub_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int unsigned INT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    scrub_state_t      state;
    logic [CW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] scrub_ptr;
    logic [INT_W-1:0]  ivl_cnt;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [ADDR_W-1:0] rd_addr;
    dec_res_t          dec;
    logic              host_rd;
    logic              host_wr;
    logic              dec_event;
    logic [CW-1:0]     enc_host;
    logic [CW-1:0]     enc_wb;

    // Single shared read port: the scrubber owns it only in SCRUB_RD, when the host is stalled.
    assign rd_addr   = (state == SCRUB_RD) ? scrub_ptr : req_addr;
    assign host_rd   = req_valid & req_ready & ~req_we;
    assign host_wr   = req_valid & req_ready & req_we;
    assign dec_event = host_rd | (state == SCRUB_RD);
    assign enc_host  = CW'(encode(DATA_W, MAX_DATA_W'(req_wdata)));
    assign enc_wb    = CW'(encode(DATA_W, MAX_DATA_W'(wb_data)));

    ecc_secded_dec #(.DATA_W(DATA_W)) u_dec (
        .codeword (mem[rd_addr]),
        .result   (dec)
    );

    if (DATA_W < MAX_DATA_W) begin : g_dec_hi
        logic unused_dec_hi;
        assign unused_dec_hi = ^dec.data[MAX_DATA_W-1:DATA_W];
    end

    // Storage, host response and scrub FSM; req_ready is registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            scrub_ptr <= '0;
            ivl_cnt   <= '0;
            wb_addr   <= '0;
            wb_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_ce    <= 1'b0;
            rsp_ue    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rsp_valid <= host_rd;
            if (host_rd) begin
                rsp_rdata <= dec.data[DATA_W-1:0];
                rsp_ce    <= dec.ce;
                rsp_ue    <= dec.ue;
            end
            if (host_wr) mem[req_addr] <= enc_host ^ inj_mask;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (scrub_en) begin
                        if (ivl_cnt == INT_W'(SCRUB_INTERVAL - 1)) begin
                            state     <= SCRUB_RD;
                            req_ready <= 1'b0;
                            ivl_cnt   <= '0;
                        end else begin
                            ivl_cnt <= ivl_cnt + INT_W'(1);
                        end
                    end
                end
                SCRUB_RD: begin
                    scrub_ptr <= (scrub_ptr == ADDR_W'(DEPTH - 1)) ? '0 : scrub_ptr + ADDR_W'(1);
                    if (dec.ce) begin
                        state   <= SCRUB_WB;
                        wb_addr <= scrub_ptr;
                        wb_data <= dec.data[DATA_W-1:0];
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                SCRUB_WB: begin
                    mem[wb_addr] <= enc_wb;
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error counters; a clear drops any same-cycle event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ce_count <= '0;
            ue_count <= '0;
            err_addr <= '0;
        end else if (cnt_clr) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (dec_event) begin
            if (dec.ce && (ce_count != {CNT_W{1'b1}})) ce_count <= ce_count + CNT_W'(1);
            if (dec.ue && (ue_count != {CNT_W{1'b1}})) ue_count <= ue_count + CNT_W'(1);
            if (dec.ce || dec.ue) err_addr <= rd_addr;
        end
    end

endmodule

// File: tb/tb_ecc_scrub_mem.sv
// tb_ecc_scrub_mem: directed + randomized self-checking bench for ecc_scrub_mem.
// Reference model keeps plain data plus the injected error mask per word and
// predicts outcomes from the error weight (0 clean, 1 corrected, 2 detected).
module tb_ecc_scrub_mem;

    localparam int unsigned DATA_W  = 11;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CW      = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned SI      = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ce;
    logic              rsp_ue;
    logic [CW-1:0]     inj_mask;
    logic              scrub_en;
    logic              cnt_clr;
    logic [CNT_W-1:0]  ce_count;
    logic [CNT_W-1:0]  ue_count;
    logic [AW-1:0]     err_addr;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] m_data [DEPTH];
    logic [CW-1:0]     m_mask [DEPTH];
    int                ce_m;
    int                ue_m;
    int                err_m;

    always #5 clock = ~clock;

    ecc_scrub_mem #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ce(rsp_ce), .rsp_ue(rsp_ue),
        .inj_mask(inj_mask), .scrub_en(scrub_en), .cnt_clr(cnt_clr),
        .ce_count(ce_count), .ue_count(ue_count), .err_addr(err_addr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_mask[i] = '0;
        end
        ce_m  = 0;
        ue_m  = 0;
        err_m = 0;
    endtask

    task automatic host_write(input int a, input logic [DATA_W-1:0] d, input logic [CW-1:0] mask);
        check("wr_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = AW'(a);
        req_wdata = d;
        inj_mask  = mask;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        inj_mask  = '0;
        m_data[a] = d;
        m_mask[a] = mask;
        check("wr_no_rsp", 32'(rsp_valid), 0);
    endtask

    task automatic host_read(input string tag, input int a, input logic [DATA_W-1:0] ed,
                             input bit ece, input bit eue, input bit clr);
        check({tag, "_ready"}, 32'(req_ready), 1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(a);
        cnt_clr   = clr;
        tick();
        req_valid = 1'b0;
        cnt_clr   = 1'b0;
        if (clr) begin
            ce_m = 0;
            ue_m = 0;
        end else begin
            if (ece && ce_m < CNT_MAX) ce_m++;
            if (eue && ue_m < CNT_MAX) ue_m++;
            if (ece || eue) err_m = a;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        check({tag, "_rdata"}, 32'(rsp_rdata), 32'(ed));
        check({tag, "_ce"}, 32'(rsp_ce), 32'(ece));
        check({tag, "_ue"}, 32'(rsp_ue), 32'(eue));
        check({tag, "_ce_count"}, 32'(ce_count), 32'(ce_m));
        check({tag, "_ue_count"}, 32'(ue_count), 32'(ue_m));
        check({tag, "_err_addr"}, 32'(err_addr), 32'(err_m));
    endtask

    // Prediction from error weight only; model words never carry 3+ flips.
    task automatic model_read(input string tag, input int a, input bit clr);
        int                w;
        logic [DATA_W-1:0] d;
        bit                ce;
        bit                ue;
        w  = $countones(m_mask[a]);
        d  = m_data[a];
        ce = (w == 1);
        ue = (w == 2);
        if (ue) d = m_data[a] ^ m_mask[a][DATA_W-1:0];
        host_read(tag, a, d, ce, ue, clr);
    endtask

    function automatic logic [CW-1:0] rand_mask();
        logic [CW-1:0] m;
        int            w;
        int            p1;
        int            p2;
        m  = '0;
        w  = $urandom_range(0, 2);
        p1 = $urandom_range(0, CW - 1);
        p2 = (p1 + $urandom_range(1, CW - 1)) % CW;
        if (w >= 1) m[p1] = 1'b1;
        if (w == 2) m[p2] = 1'b1;
        return m;
    endfunction

    task automatic rewrite_clean();
        for (int i = 0; i < DEPTH; i++) host_write(i, DATA_W'($urandom), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        inj_mask  = '0;
        scrub_en  = 1'b0;
        cnt_clr   = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ce_count", 32'(ce_count), 0);
        check("rst_ue_count", 32'(ue_count), 0);
        check("rst_err_addr", 32'(err_addr), 0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("post_rst_ready", 32'(req_ready), 1);
        model_read("rst_word", 9, 1'b0);

        // Clean write/read and single-cycle response
        host_write(2, 11'h5A3, 16'h0000);
        host_read("clean", 2, 11'h5A3, 1'b0, 1'b0, 1'b0);
        tick();
        check("rsp_one_cycle", 32'(rsp_valid), 0);

        // Single data-bit error
        host_write(3, 11'h5A3, 16'h0001);
        host_read("ce_d0", 3, 11'h5A3, 1'b1, 1'b0, 1'b0);
        check("ce_count_is_1", 32'(ce_count), 1);
        check("err_addr_is_3", 32'(err_addr), 3);

        // Double error, then overall-parity-bit error
        host_write(4, 11'h5A3, 16'h0003);
        host_read("ue_d01", 4, 11'h5A0, 1'b0, 1'b1, 1'b0);
        check("ue_count_is_1", 32'(ue_count), 1);
        host_write(5, 11'h5A3, 16'h8000);
        host_read("ce_par", 5, 11'h5A3, 1'b1, 1'b0, 1'b0);

        // Layout checks: data[10],[9],[8] sit at positions 3,5,6 (syndrome 0, parity odd)
        host_write(6, 11'h5A3, 16'h0700);
        host_read("lay_356", 6, 11'h2A3, 1'b1, 1'b0, 1'b0);
        // data[0]@15 ^ check0@1 ^ check1@2 -> syndrome 12 = data[3]
        host_write(7, 11'h5A3, 16'h1801);
        host_read("lay_mis", 7, 11'h5AA, 1'b1, 1'b0, 1'b0);
        host_read("ce_sat", 3, 11'h5A3, 1'b1, 1'b0, 1'b0);
        check("ce_count_sat", 32'(ce_count), 3);
        host_read("clr_evt", 5, 11'h5A3, 1'b1, 1'b0, 1'b1);
        check("clr_ce_zero", 32'(ce_count), 0);
        check("clr_ue_zero", 32'(ue_count), 0);

        // Randomized host traffic against the model
        rewrite_clean();
        for (int it = 0; it < 80; it++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 1)
                host_write(a, DATA_W'($urandom), rand_mask());
            else
                model_read("rnd", a, ($urandom_range(0, 9) == 0));
        end

        // Scrubber: corrects addr 0 with a write-back, then visits clean addr 1
        rewrite_clean();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        ce_m = 0;
        ue_m = 0;
        check("scrub_clr", 32'(ce_count), 0);
        host_write(0, 11'h3C5, 16'h0004);
        scrub_en = 1'b1;
        for (int s = 0; s < 2; s++) begin
            n = 0;
            while (req_ready && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("scrub%0d_interval", s), 32'(n), SI);
            low = 0;
            while (!req_ready && low < 10) begin
                tick();
                low++;
            end
            check($sformatf("scrub%0d_busy_len", s), 32'(low), (s == 0) ? 2 : 1);
        end
        scrub_en  = 1'b0;
        m_mask[0] = '0;
        ce_m      = 1;
        err_m     = 0;
        check("scrub_ce_count", 32'(ce_count), 1);
        host_read("after_scrub", 0, 11'h3C5, 1'b0, 1'b0, 1'b0);

        // Reset during the write-back of addr 2
        host_write(2, 11'h1F0, 16'h0020);
        scrub_en = 1'b1;
        n = 0;
        while (req_ready && n < 100) begin
            tick();
            n++;
        end
        check("wb_scrub_start", 32'(n < 100), 1);
        tick();
        check("in_wb_busy", 32'(req_ready), 0);
        reset_n  = 1'b0;
        scrub_en = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_ce_count", 32'(ce_count), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        host_read("rst_wb_a2", 2, 11'h000, 1'b0, 1'b0, 1'b0);
        host_read("rst_wb_a0", 0, 11'h000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
